// File: rtl/out_port_arbiter.sv
// Wormhole switch allocator for one mesh-router output port: round-robin
// arbitration on head flits, grant held until the tail flit passes, registered output stage.
module out_port_arbiter #(
  parameter int FLIT_W = 8,
  parameter int NUM_IN = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        valid,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        pop,
  output logic [NUM_IN-1:0]        grant,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     flit_out_valid,
  output logic                     proto_err
);

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_TAIL     = 2'b01,
    FT_HDR      = 2'b10,
    FT_HDR_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_IN - 1);

  state_e                  state_q;
  logic [2:0]              ptr_q;
  logic [2:0]              owner_q;
  logic                    head_sent_q;
  logic [NUM_IN-1:0]       grant_q;
  logic [FLIT_W-1:0]       flit_out_q;
  logic                    flit_out_valid_q;
  logic                    proto_err_q;

  flit_type_e              in_type [NUM_IN];
  logic [NUM_IN-1:0]       cand;
  logic [NUM_IN-1:0]       bad_head;
  logic                    win_found;
  logic [2:0]              win_d;
  logic [2:0]              scan;
  logic [NUM_IN-1:0]       grant_d;
  logic [FLIT_W-1:0]       flit_out_d;
  flit_type_e              owner_type;
  logic                    owner_pop;

  // Classify every input's head-of-buffer flit.
  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cand     = '0;
    bad_head = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_type[i]  = flit_type_e'(flit_in[i*FLIT_W + FLIT_W - 2 +: 2]);
      cand[i]     = req[i] && valid[i] &&
                    (in_type[i] == FT_HDR || in_type[i] == FT_HDR_TAIL);
      bad_head[i] = req[i] && valid[i] &&
                    (in_type[i] == FT_BODY || in_type[i] == FT_TAIL);
    end
  end

  // Round-robin scan starting just after the last winner, wrapping 4 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_d     = '0;
    scan      = ptr_q;
    for (int k = 0; k < NUM_IN; k++) begin
      scan = (scan == LAST_IDX) ? 3'd0 : scan + 3'd1;
      if (!win_found && cand[scan]) begin
        win_found = 1'b1;
        win_d     = scan;
      end
    end
    grant_d = {{(NUM_IN-1){1'b0}}, 1'b1} << win_d;
  end

  always_comb begin
    flit_out_d = flit_in[int'(owner_q)*FLIT_W +: FLIT_W];
    owner_type = flit_type_e'(flit_out_d[FLIT_W-1 -: 2]);
    owner_pop  = (state_q == S_LOCKED) && valid[owner_q] && out_ready;
    pop        = '0;
    pop[owner_q] = owner_pop;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      ptr_q            <= LAST_IDX;
      owner_q          <= '0;
      head_sent_q      <= 1'b0;
      grant_q          <= '0;
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
      proto_err_q      <= 1'b0;
    end else begin
      flit_out_valid_q <= 1'b0;
      proto_err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q     <= S_LOCKED;
            grant_q     <= grant_d;
            ptr_q       <= win_d;
            owner_q     <= win_d;
            head_sent_q <= 1'b0;
          end else begin
            proto_err_q <= |bad_head;
          end
        end
        S_LOCKED: begin
          if (owner_pop) begin
            flit_out_q       <= flit_out_d;
            flit_out_valid_q <= 1'b1;
            head_sent_q      <= 1'b1;
            // A head flit after the packet's own head is forwarded but flagged.
            proto_err_q      <= head_sent_q &&
                                (owner_type == FT_HDR || owner_type == FT_HDR_TAIL);
            if (owner_type == FT_TAIL || owner_type == FT_HDR_TAIL) begin
              state_q <= S_IDLE;
              grant_q <= '0;
            end
          end
        end
      endcase
    end
  end

  assign grant          = grant_q;
  assign flit_out       = flit_out_q;
  assign flit_out_valid = flit_out_valid_q;
  assign proto_err      = proto_err_q;

  a_pop_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(pop));
  a_pop_owned   : assert property (@(posedge clk) disable iff (rst) (pop & ~grant_q) == '0);
  a_grant_oh0   : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter: directed scenarios plus random
// packet traffic compared against a packet-level reference model.
module tb_out_port_arbiter;

  localparam int FW = 8;
  localparam int N  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    valid;
  logic [N*FW-1:0] flit_in;
  logic            out_ready;
  logic [N-1:0]    pop;
  logic [N-1:0]    grant;
  logic [FW-1:0]   flit_out;
  logic            flit_out_valid;
  logic            proto_err;

  always #5 clk = ~clk;

  out_port_arbiter #(.FLIT_W(FW), .NUM_IN(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .valid          (valid),
    .flit_in        (flit_in),
    .out_ready      (out_ready),
    .pop            (pop),
    .grant          (grant),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .proto_err      (proto_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Upstream input buffers, one flit queue per input.
  logic [7:0] fifo [N][$];
  bit [N-1:0] req_en;
  bit         ready_v;

  // Reference model: packet-level view of who owns the port.
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  bit         m_head_seen;
  logic [N-1:0] e_grant;
  logic [N-1:0] e_pop;
  logic       e_fv;
  logic       e_perr;
  logic [7:0] e_flit;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 4; m_head_seen = 0;
    e_grant = '0; e_pop = '0; e_fv = 0; e_perr = 0; e_flit = 8'h00;
  endfunction

  function automatic void model_step();
    int w;
    int i;
    bit any_bad;
    logic [7:0] f;
    e_pop  = '0;
    e_fv   = 0;
    e_perr = 0;
    if (!m_busy) begin
      w = -1;
      any_bad = 0;
      for (int k = 1; k <= N; k++) begin
        i = (m_ptr + k) % N;
        f = flit_in[i*FW +: FW];
        if (req[i] && valid[i]) begin
          if (f[7]) begin
            if (w < 0) w = i;
          end else begin
            any_bad = 1;
          end
        end
      end
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_ptr = w; m_head_seen = 0;
        e_grant = 5'(1 << w);
      end else begin
        e_perr = any_bad;
      end
    end else begin
      f = flit_in[m_owner*FW +: FW];
      if (valid[m_owner] && out_ready) begin
        e_pop[m_owner] = 1'b1;
        e_fv   = 1;
        e_flit = f;
        e_perr = f[7] && m_head_seen;
        m_head_seen = 1;
        if (f[6]) begin
          m_busy  = 0;
          e_grant = '0;
        end
      end
    end
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      valid[i]            = fifo[i].size() > 0;
      flit_in[i*FW +: FW] = valid[i] ? fifo[i][0] : 8'h00;
      req[i]              = valid[i] && req_en[i];
    end
    out_ready = ready_v;
  endtask

  // One clock cycle, starting and ending at a falling edge.
  task automatic step();
    drive_inputs();
    #1;
    model_step();
    check("pop", pop, e_pop);
    for (int i = 0; i < N; i++) if (e_pop[i]) void'(fifo[i].pop_front());
    @(posedge clk);
    @(negedge clk);
    check("grant", grant, e_grant);
    check("fout_valid", flit_out_valid, e_fv);
    check("fout", flit_out, e_flit);
    check("proto_err", proto_err, e_perr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) fifo[i].delete();
    req_en  = '1;
    ready_v = 1;
    drive_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_fv", flit_out_valid, 0);
    check("rst_fout", flit_out, 0);
    check("rst_perr", proto_err, 0);
  endtask

  task automatic push_random_packet(input int i);
    int len;
    len = $urandom_range(1, 4);
    if (len == 1) begin
      fifo[i].push_back({2'b11, 6'($urandom)});
    end else begin
      fifo[i].push_back({2'b10, 6'($urandom)});
      for (int b = 0; b < len - 2; b++) fifo[i].push_back({2'b00, 6'($urandom)});
      fifo[i].push_back({2'b01, 6'($urandom)});
    end
  endtask

  logic [7:0] pkt2 [4] = '{8'h85, 8'h11, 8'h22, 8'h43};
  logic [7:0] pkt3 [4] = '{8'h81, 8'h0A, 8'h0B, 8'h4C};
  int order [$];
  logic [N-1:0] prev_grant;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; valid = '0; flit_in = '0; out_ready = 1'b1;
    @(negedge clk);

    // Two single-flit packets on inputs 0 and 2 after reset.
    do_reset();
    fifo[0].push_back(8'hC5);
    fifo[2].push_back(8'hCA);
    step(); check("t1_grant0", grant, 5'b00001);
    step(); check("t1_flit0", {flit_out_valid, flit_out}, {1'b1, 8'hC5});
    step(); check("t1_grant2", grant, 5'b00100);
    step(); check("t1_flit2", {flit_out_valid, flit_out}, {1'b1, 8'hCA});
    // ptr now 2: input 3 wins over input 1.
    fifo[1].push_back(8'hC1);
    fifo[3].push_back(8'hC3);
    step(); check("t1_ptr", grant, 5'b01000);
    step();
    step(); check("t1_next", grant, 5'b00010);
    step();

    // Four-flit packet on input 3, no stalls.
    for (int k = 0; k < 4; k++) fifo[3].push_back(pkt2[k]);
    step(); check("t2_grant", grant, 5'b01000);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t2_flit%0d", k), {flit_out_valid, flit_out}, {1'b1, pkt2[k]});
      check($sformatf("t2_grant%0d", k), grant, (k < 3) ? 5'b01000 : 5'b00000);
    end

    // Input 1 stalled by out_ready for three cycles mid-packet.
    for (int k = 0; k < 4; k++) fifo[1].push_back(pkt3[k]);
    step(); check("t3_grant", grant, 5'b00010);
    step(); step();
    check("t3_flit1", flit_out, pkt3[1]);
    ready_v = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("t3_stall_pop", pop, 0);
      check("t3_stall_fv", flit_out_valid, 0);
      check("t3_stall_grant", grant, 5'b00010);
    end
    ready_v = 1;
    step(); check("t3_flit2", {flit_out_valid, flit_out}, {1'b1, pkt3[2]});
    step(); check("t3_flit3", {flit_out_valid, flit_out}, {1'b1, pkt3[3]});
    check("t3_release", grant, 0);

    // All five inputs requesting continuously: fair rotation from input 0.
    do_reset();
    prev_grant = '0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) if (fifo[i].size() == 0) fifo[i].push_back(8'hC0 | 8'(i));
      step();
      if (grant != 0 && prev_grant == 0)
        for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
      prev_grant = grant;
    end
    check("t4_count", order.size() >= 6, 1);
    for (int k = 0; k < 6 && k < order.size(); k++)
      check($sformatf("t4_order%0d", k), order[k], k % N);
    for (int c = 0; c < 20; c++) step();

    // Body flit presented while idle.
    do_reset();
    fifo[4].push_back(8'h05);
    step();
    check("t5_perr", proto_err, 1);
    check("t5_grant", grant, 0);
    fifo[4].delete();
    step();
    check("t5_perr_clr", proto_err, 0);

    // Second header inside a locked packet is forwarded and flagged.
    fifo[0].push_back(8'h80);
    fifo[0].push_back(8'h82);
    fifo[0].push_back(8'h43);
    step(); step();
    check("t5b_head_ok", proto_err, 0);
    step();
    check("t5b_dup_hdr", {proto_err, flit_out_valid, flit_out}, {1'b1, 1'b1, 8'h82});
    step();
    check("t5b_tail", {proto_err, grant}, {1'b0, 5'b00000});

    // Asynchronous reset mid-packet on input 2.
    do_reset();
    fifo[2].push_back(8'h88);
    fifo[2].push_back(8'h01);
    fifo[2].push_back(8'h02);
    fifo[2].push_back(8'h03);
    fifo[2].push_back(8'h44);
    step(); step(); step();
    check("t6_locked", grant, 5'b00100);
    #2 rst = 1'b1;
    #1;
    check("t6_grant", grant, 0);
    check("t6_fv", flit_out_valid, 0);
    check("t6_fout", flit_out, 0);
    check("t6_perr", proto_err, 0);
    check("t6_pop", pop, 0);
    for (int i = 0; i < N; i++) fifo[i].delete();
    drive_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    fifo[2].push_back(8'h87);
    fifo[2].push_back(8'h47);
    step(); check("t6_regrant", grant, 5'b00100);
    step(); step();
    check("t6_done", {flit_out, grant}, {8'h47, 5'b00000});

    // Random traffic with stalls and dropped requests.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (fifo[i].size() < 3 && $urandom_range(0, 3) == 0) push_random_packet(i);
      ready_v = $urandom_range(0, 4) != 0;
      for (int i = 0; i < N; i++) req_en[i] = $urandom_range(0, 7) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
